// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART RX sampling/deserializing stage.
package uart_rx_pkg;

  // Frame FSM states. The encoding is also visible on the top's fsm_state
  // debug output, so keep it stable.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Supported oversampling ratios.
  localparam logic [4:0] PRESCALE_8  = 5'd8;
  localparam logic [4:0] PRESCALE_16 = 5'd16;

  // Edge index of the bit centre. Only 16 gets its own centre; every other
  // prescale value falls back to the x8 centre.
  function automatic logic [4:0] mid_point(input logic [4:0] prescale);
    if (prescale == PRESCALE_16) begin
      return PRESCALE_16 >> 1;
    end
    return PRESCALE_8 >> 1;
  endfunction

  // Two-out-of-three vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_majority_sampler.sv
// Captures rx_in at mid-1, mid and mid+1 of each bit period and emits the
// majority vote as a one-cycle strobe on the cycle after the last capture.
// The third sample is not stored: it is voted straight from rx_in on the
// capture edge, so sampled_bit/sampled_valid come out of registers with
// exactly one cycle of latency after the mid+1 edge.
module uart_rx_majority_sampler
  import uart_rx_pkg::*;
#(
  parameter int EDGE_CNT_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic [4:0]                prescale,
  input  logic [EDGE_CNT_WIDTH-1:0] edge_cnt,
  input  logic                      frame_active,
  output logic                      sampled_bit,
  output logic                      sampled_valid
);

  logic [EDGE_CNT_WIDTH-1:0] mid;
  logic [EDGE_CNT_WIDTH-1:0] mid_lo;
  logic [EDGE_CNT_WIDTH-1:0] mid_hi;
  logic                      s0;
  logic                      s1;

  assign mid    = EDGE_CNT_WIDTH'(mid_point(prescale));
  assign mid_lo = mid - EDGE_CNT_WIDTH'(1);
  assign mid_hi = mid + EDGE_CNT_WIDTH'(1);

  // Capture the two early samples; clear them whenever no frame is running.
  always_ff @(posedge clk) begin
    if (rst || !frame_active) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      if (edge_cnt == mid_lo) s0 <= rx_in;
      if (edge_cnt == mid)    s1 <= rx_in;
    end
  end

  // Vote on the mid+1 edge and publish the result for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sampled_bit   <= 1'b0;
      sampled_valid <= 1'b0;
    end else begin
      sampled_valid <= 1'b0;
      if (frame_active && (edge_cnt == mid_hi)) begin
        sampled_bit   <= majority3(s0, s1, rx_in);
        sampled_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_sample_deser.sv
// UART RX sample/deserialize stage: votes each bit period, walks the frame
// (start, data, optional parity, stop), shifts data in LSB-first and reports
// one outcome per frame.
//
// Output handshake: there is no ready. data_valid is a one-cycle strobe and
// p_data is valid from that cycle until the next good frame; par_err,
// stop_err and strt_glitch are one-cycle strobes, and at most one of the four
// fires per frame.
module uart_rx_sample_deser
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int EDGE_CNT_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic [4:0]                prescale,
  input  logic [EDGE_CNT_WIDTH-1:0] edge_cnt,
  input  logic                      frame_active,
  input  logic                      par_en,
  input  logic                      par_typ,
  output logic                      sampled_bit,
  output logic                      sampled_valid,
  output logic [DATA_WIDTH-1:0]     p_data,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stop_err,
  output logic                      strt_glitch,
  output logic [2:0]                fsm_state
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                state;
  state_t                state_next;
  logic                  frame_active_q;
  logic                  frame_rise;
  logic                  abort;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0]      bit_idx;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_fail;

  // Control strobes decoded from the current state.
  logic cfg_latch;
  logic start_ok;
  logic glitch_hit;
  logic shift_en;
  logic par_chk;
  logic stop_chk;

  uart_rx_majority_sampler #(
    .EDGE_CNT_WIDTH (EDGE_CNT_WIDTH)
  ) u_sampler (
    .clk           (clk),
    .rst           (rst),
    .rx_in         (rx_in),
    .prescale      (prescale),
    .edge_cnt      (edge_cnt),
    .frame_active  (frame_active),
    .sampled_bit   (sampled_bit),
    .sampled_valid (sampled_valid)
  );

  assign fsm_state  = state;
  assign frame_rise = frame_active && !frame_active_q;
  // Losing frame_active outranks any sample arriving in the same cycle.
  assign abort      = (state != ST_IDLE) && !frame_active;

  // Remember the previous frame_active level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) frame_active_q <= 1'b0;
    else     frame_active_q <= frame_active;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_next = state;
    cfg_latch  = 1'b0;
    start_ok   = 1'b0;
    glitch_hit = 1'b0;
    shift_en   = 1'b0;
    par_chk    = 1'b0;
    stop_chk   = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          // Only a fresh rising edge starts a frame, so after a start
          // glitch the rest of that frame is ignored.
          if (frame_rise) begin
            state_next = ST_START;
            cfg_latch  = 1'b1;
          end
        end
        ST_START: begin
          if (sampled_valid) begin
            if (sampled_bit) begin
              glitch_hit = 1'b1;
              state_next = ST_IDLE;
            end else begin
              start_ok   = 1'b1;
              state_next = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sampled_valid) begin
            shift_en = 1'b1;
            if (bit_idx == LAST_IDX) begin
              state_next = par_en_q ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (sampled_valid) begin
            par_chk    = 1'b1;
            state_next = ST_STOP;
          end
        end
        ST_STOP: begin
          if (sampled_valid) begin
            stop_chk   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Frame configuration, shift register, bit index and parity tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_fail  <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      if (cfg_latch) begin
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        par_fail  <= 1'b0;
      end
      if (abort || start_ok) begin
        bit_idx  <= '0;
        par_fail <= 1'b0;
      end
      if (shift_en) begin
        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
        bit_idx   <= bit_idx + IDX_W'(1);
      end
      if (par_chk && (sampled_bit != ((^shift_reg) ^ par_typ_q))) begin
        par_fail <= 1'b1;
      end
    end
  end

  // Registered frame outcome: exactly one strobe for the deciding sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stop_err    <= 1'b0;
      strt_glitch <= 1'b0;
    end else begin
      strt_glitch <= glitch_hit;
      stop_err    <= stop_chk && !sampled_bit;
      par_err     <= stop_chk && sampled_bit && par_fail;
      data_valid  <= stop_chk && sampled_bit && !par_fail;
      if (stop_chk && sampled_bit && !par_fail) begin
        p_data <= shift_reg;
      end
    end
  end

endmodule

// File: doc/uart_rx_sample_deser.md
Name: uart_rx_sample_deser

Overview:
- Datapath/control stage directly downstream of the UART RX oversampling edge/bit counter.
- Takes the running edge count, majority-votes three mid-bit samples of rx_in into one bit per bit period, and steps a frame FSM (start, data, parity, stop).
- Deserializes data LSB-first and checks start, parity and stop.
- Produces the received byte plus a one-cycle valid strobe and per-frame error flags for the UART RX top.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- EDGE_CNT_WIDTH, 5, width of the edge_cnt input; must hold prescale-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_in  in  1  serial line, already synchronized; idle high.
- prescale  in  5  oversampling ratio; 8 and 16 supported.
- edge_cnt  in  EDGE_CNT_WIDTH  edge index within the current bit period, 0..prescale-1, from the edge/bit counter.
- frame_active  in  1  high while the counter is running a frame; a low level aborts the frame.
- par_en  in  1  1 = frame carries a parity bit.
- par_typ  in  1  0 = even, 1 = odd.
- sampled_bit  out  1  majority result of the last bit period.
- sampled_valid  out  1  one-cycle pulse; sampled_bit is new.
- p_data  out  DATA_WIDTH  last received word; holds until the next good frame.
- data_valid  out  1  one-cycle pulse on a good frame.
- par_err  out  1  one-cycle pulse; parity mismatch.
- stop_err  out  1  one-cycle pulse; stop bit sampled 0.
- strt_glitch  out  1  one-cycle pulse; start bit sampled 1.

Behaviour:
- Reset: while rst=1 at a clk edge, FSM goes to IDLE. All pulses, sampled_bit, p_data, shift register and bit index clear to 0. rst takes priority over every other event.
- Mid point: mid = prescale>>1, so 4 for prescale 8 and 8 for prescale 16. Any other prescale value is treated as 8.
- Sampling:
  - Capture rx_in when edge_cnt = mid-1, mid and mid+1, and frame_active=1.
  - On the cycle after the mid+1 capture: sampled_bit = majority(s0,s1,s2) and sampled_valid=1 for exactly one cycle.
  - Sample registers clear when frame_active=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: move to START on rising frame_active.
  - START, on sampled_valid:
    - bit=0: go to DATA, bit index = 0.
    - bit=1: pulse strt_glitch, go to IDLE. Stay in IDLE until frame_active falls and rises again.
  - DATA, on sampled_valid:
    - Shift right with sampled_bit entering the MSB (LSB-first line order); increment the bit index.
    - After DATA_WIDTH bits: go to PARITY if par_en=1, else STOP.
  - PARITY, on sampled_valid:
    - Expected parity = XOR of data bits, XOR par_typ.
    - On mismatch set an internal par_fail flag. Always go to STOP.
  - STOP, on sampled_valid (outputs on the next cycle, then go to IDLE):
    - bit=0: pulse stop_err.
    - par_fail=1: pulse par_err.
    - bit=1 and par_fail=0: load p_data from the shift register and pulse data_valid.
    - Only these outcomes; no other output activity.
- Latency: data_valid is asserted 2 cycles after the stop bit's edge_cnt = mid+1 cycle (1 cycle vote, 1 cycle output register).
- Abort: frame_active=0 in any non-IDLE state sends the FSM to IDLE next cycle. No flags pulse, p_data is unchanged, and par_fail clears.
- Config changes: par_en and par_typ are sampled when START is entered and held for the frame. A mid-frame change has no effect.
- Simultaneity: frame_active falling in the same cycle as a sampled_valid: the abort wins and the sample is discarded.
- All pulses are mutually exclusive within a frame. At most one of data_valid, par_err, stop_err or strt_glitch fires per frame.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - PRESCALE_8 and PRESCALE_16 constants;
  - a function returning mid for a given prescale.
- One sub-module, uart_rx_majority_sampler:
  - holds the three-sample capture and vote, and produces sampled_bit and sampled_valid;
  - the parent holds the FSM, shift register and checks.

Test Plan:
- prescale=8, par_en=0, frame 0x55 sent cleanly -> exactly one data_valid, p_data=0x55, no error pulses; data_valid is 2 cycles after the stop bit's edge_cnt=5.
- prescale=16, par_en=1, par_typ=0, byte 0xA3 with parity bit 0 -> data_valid, p_data=0xA3. Repeat with parity bit 1 -> par_err only, p_data keeps the prior value.
- prescale=8: rx_in held 1 through the start-bit mid samples -> strt_glitch pulse, FSM back in IDLE, no data_valid for the rest of the frame.
- prescale=16, byte 0x0F, stop bit driven 0 -> stop_err pulse, no data_valid.
- Single-cycle 0 glitch on rx_in at edge_cnt=mid during a 1 data bit -> vote yields 1, byte received correctly.
- frame_active dropped after 4 data bits, then a clean frame of 0x3C -> no pulses on the aborted frame, then data_valid with p_data=0x3C. Separately, rst=1 mid-frame -> all outputs 0 on the next cycle.
